// File: rtl/morra_pkg.sv
// Shared types for the Morra game block.
// - state_e   : top-level FSM states
// - outcome_e : per-round outcome codes driven on ROUND
// - game_e    : game result codes driven on GAME
// - CountW    : width of the PLAYED and LEAD counters
package morra_pkg;

  localparam int unsigned CountW = 5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPlay = 2'd1,
    StDone = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OutInvalid = 2'b00,
    OutP1Win   = 2'b01,
    OutP2Win   = 2'b10,
    OutDraw    = 2'b11
  } outcome_e;

  typedef enum logic [1:0] {
    GameNone = 2'b00,
    GameP1   = 2'b01,
    GameP2   = 2'b10,
    GameDraw = 2'b11
  } game_e;

endpackage

// File: rtl/morra_game_par_if.sv
// Player/result bundle of the Morra game block.
// - start       : synchronous game start
// - p1, p2      : player moves (extra-round count halves on a start cycle)
// - round       : registered round outcome
// - round_valid : one-cycle pulse when round carries a PLAY result
// - game        : registered game result
// - played      : valid rounds in the current game
// - lead        : signed lead, player 1 positive
// master drives moves and samples results; slave is the game block.
interface morra_game_par_if
  import morra_pkg::*;
#(
  parameter int unsigned MOVE_W = 2
) ();

  logic                     start;
  logic [MOVE_W-1:0]        p1;
  logic [MOVE_W-1:0]        p2;
  logic [1:0]               round;
  logic                     round_valid;
  logic [1:0]               game;
  logic [CountW-1:0]        played;
  logic signed [CountW-1:0] lead;

  modport master (
    output start, p1, p2,
    input  round, round_valid, game, played, lead
  );

  modport slave (
    input  start, p1, p2,
    output round, round_valid, game, played, lead
  );

endinterface

// File: rtl/morra_judge.sv
// Combinational round judge.
// - p1, p2    : moves of this round
// - prev_win  : winner of the last valid round (OutInvalid when none / last was a draw)
// - prev_move : move the last winner won with
// - outcome   : OutInvalid, OutP1Win, OutP2Win or OutDraw
module morra_judge
  import morra_pkg::*;
#(
  parameter int unsigned NUM_MOVES = 3,
  parameter int unsigned MOVE_W    = 2,
  parameter int unsigned NO_REPEAT = 1
) (
  input  logic [MOVE_W-1:0] p1,
  input  logic [MOVE_W-1:0] p2,
  input  outcome_e          prev_win,
  input  logic [MOVE_W-1:0] prev_move,
  output outcome_e          outcome
);

  localparam logic [MOVE_W-1:0] MaxMove = MOVE_W'(NUM_MOVES);
  localparam int                HalfN   = int'((NUM_MOVES - 1) / 2);

  logic out_of_range;
  logic repeat_win;
  int   diff;

  always_comb begin
    out_of_range = (p1 == '0) || (p2 == '0) || (p1 > MaxMove) || (p2 > MaxMove);
    repeat_win   = (NO_REPEAT != 0) &&
                   (((prev_win == OutP1Win) && (p1 == prev_move)) ||
                    ((prev_win == OutP2Win) && (p2 == prev_move)));
    // Both moves lie in 1..NUM_MOVES here, so one +N corrects a negative difference.
    diff = int'(p1) - int'(p2);
    if (diff < 0) diff = diff + int'(NUM_MOVES);

    outcome = OutInvalid;
    if (!out_of_range && !repeat_win) begin
      if (diff == 0)          outcome = OutDraw;
      else if (diff <= HalfN) outcome = OutP1Win;
      else                    outcome = OutP2Win;
    end
  end

endmodule

// File: rtl/morra_game_par.sv
// Morra game controller: FSM, round counters, round target and output registers.
// - clk  : clock, rising edge
// - rst  : asynchronous active-high reset
// - bus  : player/result bundle (slave side)
module morra_game_par
  import morra_pkg::*;
#(
  parameter int unsigned NUM_MOVES  = 3,
  parameter int unsigned MOVE_W     = 2,
  parameter int unsigned MIN_ROUNDS = 4,
  parameter int unsigned MAX_ROUNDS = 31,
  parameter int unsigned ADV_LIMIT  = 2,
  parameter int unsigned NO_REPEAT  = 1
) (
  input logic             clk,
  input logic             rst,
  morra_game_par_if.slave bus
);

  // |lead| can never exceed max(MIN_ROUNDS, ADV_LIMIT): below MIN_ROUNDS it is bounded by
  // the rounds played, afterwards the game stops as soon as it reaches ADV_LIMIT. Keeping
  // both at or under 15 therefore keeps the 5-bit signed lead exact even with MAX_ROUNDS=31.
  if (NUM_MOVES < 3 || NUM_MOVES > 7 || (NUM_MOVES % 2) == 0 ||
      (1 << MOVE_W) <= NUM_MOVES || MAX_ROUNDS > 31 || MIN_ROUNDS > MAX_ROUNDS ||
      MIN_ROUNDS > 15 || ADV_LIMIT > 15) begin : g_bad_params
    $error("morra_game_par: illegal parameter set");
  end

  state_e                   state_q, state_d;
  outcome_e                 round_q, round_d;
  logic                     round_valid_q, round_valid_d;
  game_e                    game_q, game_d;
  logic [CountW-1:0]        played_q, played_d;
  logic signed [CountW-1:0] lead_q, lead_d;
  logic [CountW-1:0]        to_play_q, to_play_d;
  outcome_e                 prev_win_q, prev_win_d;
  logic [MOVE_W-1:0]        prev_move_q, prev_move_d;

  outcome_e                 judged;
  logic [CountW-1:0]        played_n;
  logic signed [CountW-1:0] lead_n;
  int                       lead_mag;
  int unsigned              load_sum;

  morra_judge #(
    .NUM_MOVES (NUM_MOVES),
    .MOVE_W    (MOVE_W),
    .NO_REPEAT (NO_REPEAT)
  ) u_judge (
    .p1        (bus.p1),
    .p2        (bus.p2),
    .prev_win  (prev_win_q),
    .prev_move (prev_move_q),
    .outcome   (judged)
  );

  always_comb begin
    state_d       = state_q;
    round_d       = round_q;
    round_valid_d = 1'b0;
    game_d        = game_q;
    played_d      = played_q;
    lead_d        = lead_q;
    to_play_d     = to_play_q;
    prev_win_d    = prev_win_q;
    prev_move_d   = prev_move_q;

    load_sum = MIN_ROUNDS + 32'({bus.p1, bus.p2});
    played_n = played_q + 5'd1;
    lead_n   = lead_q;
    lead_mag = 0;

    if (bus.start) begin
      state_d     = StPlay;
      round_d     = OutInvalid;
      game_d      = GameNone;
      played_d    = '0;
      lead_d      = '0;
      prev_win_d  = OutInvalid;
      prev_move_d = '0;
      to_play_d   = (load_sum > MAX_ROUNDS) ? 5'(MAX_ROUNDS) : 5'(load_sum);
    end else begin
      case (state_q)
        StPlay: begin
          round_d       = judged;
          round_valid_d = 1'b1;
          if (judged != OutInvalid) begin
            if (judged == OutP1Win)      lead_n = lead_q + 5'sd1;
            else if (judged == OutP2Win) lead_n = lead_q - 5'sd1;
            played_d = played_n;
            lead_d   = lead_n;
            if (judged == OutDraw) begin
              prev_win_d = OutInvalid;
            end else begin
              prev_win_d  = judged;
              prev_move_d = (judged == OutP1Win) ? bus.p1 : bus.p2;
            end
            lead_mag = (lead_n < 0) ? -int'(lead_n) : int'(lead_n);
            if (32'(played_n) >= MIN_ROUNDS &&
                (played_n >= to_play_q || lead_mag >= int'(ADV_LIMIT))) begin
              state_d = StDone;
              game_d  = (lead_n > 0) ? GameP1 : ((lead_n < 0) ? GameP2 : GameDraw);
            end
          end
        end
        default: ; // IDLE and DONE hold everything until START
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      round_q       <= OutInvalid;
      round_valid_q <= 1'b0;
      game_q        <= GameNone;
      played_q      <= '0;
      lead_q        <= '0;
      to_play_q     <= '0;
      prev_win_q    <= OutInvalid;
      prev_move_q   <= '0;
    end else begin
      state_q       <= state_d;
      round_q       <= round_d;
      round_valid_q <= round_valid_d;
      game_q        <= game_d;
      played_q      <= played_d;
      lead_q        <= lead_d;
      to_play_q     <= to_play_d;
      prev_win_q    <= prev_win_d;
      prev_move_q   <= prev_move_d;
    end
  end

  assign bus.round       = round_q;
  assign bus.round_valid = round_valid_q;
  assign bus.game        = game_q;
  assign bus.played      = played_q;
  assign bus.lead        = lead_q;

endmodule

// File: tb/tb_morra_game_par.sv
// Self-checking bench for morra_game_par: directed vector table, hand-written reset and
// 5-move sequences, then random play against a rule-level reference model.
module tb_morra_game_par;

  localparam int NM   = 3;
  localparam int MINR = 4;
  localparam int MAXR = 31;
  localparam int ADV  = 2;
  localparam int NV   = 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  morra_game_par_if #(.MOVE_W(2)) bus ();
  morra_game_par_if #(.MOVE_W(3)) bus5 ();

  morra_game_par dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  morra_game_par #(
    .NUM_MOVES (5),
    .MOVE_W    (3),
    .NO_REPEAT (0)
  ) dut5 (
    .clk (clk),
    .rst (rst),
    .bus (bus5)
  );

  typedef struct {
    logic start;
    int   p1;
    int   p2;
    int   round;
    int   rv;
    int   game;
    int   played;
    int   lead;
    bit   chk_round;
  } vec_t;

  vec_t vecs[NV];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: st 0 idle, 1 play, 2 done; prev_who 0 none, 1 P1, 2 P2.
  int m_st, m_round, m_rv, m_game, m_played, m_lead, m_to_play, m_prev_who, m_prev_move;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] ar, input logic arv,
                           input logic [1:0] ag, input logic [4:0] ap,
                           input logic signed [4:0] al, input int r, input int rv,
                           input int g, input int p, input int l, input bit chk_r);
    if (chk_r) check({tag, ".round"}, int'(ar), r);
    check({tag, ".round_valid"}, int'(arv), rv);
    check({tag, ".game"}, int'(ag), g);
    check({tag, ".played"}, int'(ap), p);
    check({tag, ".lead"}, int'(al), l);
  endtask

  task automatic chk(input string tag, input int r, input int rv, input int g, input int p,
                     input int l, input bit chk_r);
    check_all(tag, bus.round, bus.round_valid, bus.game, bus.played, bus.lead,
              r, rv, g, p, l, chk_r);
  endtask

  task automatic chk5(input string tag, input int r, input int rv, input int g, input int p,
                      input int l);
    check_all(tag, bus5.round, bus5.round_valid, bus5.game, bus5.played, bus5.lead,
              r, rv, g, p, l, 1'b1);
  endtask

  task automatic step(input logic s, input int a, input int b);
    @(negedge clk);
    bus.start = s;
    bus.p1    = 2'(a);
    bus.p2    = 2'(b);
    @(posedge clk);
    #1;
  endtask

  task automatic step5(input logic s, input int a, input int b);
    @(negedge clk);
    bus5.start = s;
    bus5.p1    = 3'(a);
    bus5.p2    = 3'(b);
    @(posedge clk);
    #1;
  endtask

  task automatic model_cycle(input bit s, input int a, input int b);
    int o, d;
    if (s) begin
      m_st = 1; m_played = 0; m_lead = 0; m_round = 0; m_rv = 0; m_game = 0;
      m_prev_who = 0; m_prev_move = 0;
      m_to_play = MINR + a * 4 + b;
      if (m_to_play > MAXR) m_to_play = MAXR;
    end else if (m_st == 1) begin
      o = 0;
      if (a >= 1 && a <= NM && b >= 1 && b <= NM &&
          !(m_prev_who == 1 && a == m_prev_move) && !(m_prev_who == 2 && b == m_prev_move)) begin
        d = ((a - b) % NM + NM) % NM;
        o = (d == 0) ? 3 : ((d <= (NM - 1) / 2) ? 1 : 2);
      end
      m_round = o;
      m_rv    = 1;
      if (o != 0) begin
        m_played++;
        if (o == 1) m_lead++;
        if (o == 2) m_lead--;
        if (o == 3) m_prev_who = 0;
        else begin
          m_prev_who  = o;
          m_prev_move = (o == 1) ? a : b;
        end
        if (m_played >= MINR && (m_played >= m_to_play || m_lead >= ADV || -m_lead >= ADV)) begin
          m_st   = 2;
          m_game = (m_lead > 0) ? 1 : ((m_lead < 0) ? 2 : 3);
        end
      end
    end else begin
      m_rv = 0;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;  bus.p1 = '0;  bus.p2 = '0;
    bus5.start = 1'b0; bus5.p1 = '0; bus5.p2 = '0;

    // Second (2,1) repeats P1's winning move, so it is rejected and the game needs (1,3).
    vecs[0] = '{1'b1, 0, 0, 0, 0, 0, 0, 0, 1'b1};
    vecs[1] = '{1'b0, 2, 1, 1, 1, 0, 1, 1, 1'b1};
    vecs[2] = '{1'b0, 2, 1, 0, 1, 0, 1, 1, 1'b1};
    vecs[3] = '{1'b0, 3, 2, 1, 1, 0, 2, 2, 1'b1};
    vecs[4] = '{1'b0, 1, 1, 3, 1, 0, 3, 2, 1'b1};
    vecs[5] = '{1'b0, 1, 3, 1, 1, 1, 4, 3, 1'b1};
    vecs[6] = '{1'b0, 2, 1, 0, 0, 1, 4, 3, 1'b0};
    vecs[7] = '{1'b1, 1, 2, 0, 0, 0, 0, 0, 1'b1};
    for (int i = 0; i < 10; i++)
      vecs[8 + i] = '{1'b0, i % 3 + 1, i % 3 + 1, 3, 1, (i == 9) ? 3 : 0, i + 1, 0, 1'b1};
    vecs[18] = '{1'b0, 1, 2, 0, 0, 3, 10, 0, 1'b0};
    vecs[19] = '{1'b1, 3, 3, 0, 0, 0, 0, 0, 1'b1};

    #12;
    chk("reset", 0, 0, 0, 0, 0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 2, 1);
    chk("idle_ignore0", 0, 0, 0, 0, 0, 1'b1);
    step(1'b0, 3, 2);
    chk("idle_ignore1", 0, 0, 0, 0, 0, 1'b1);

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].start, vecs[i].p1, vecs[i].p2);
      chk($sformatf("vec%0d", i), vecs[i].round, vecs[i].rv, vecs[i].game, vecs[i].played,
          vecs[i].lead, vecs[i].chk_round);
    end

    // Target after START(3,3) is min(4+15,31)=19 rounds of draws.
    for (int i = 0; i < 19; i++) begin
      step(1'b0, i % 3 + 1, i % 3 + 1);
      chk($sformatf("draw19_%0d", i), 3, 1, (i == 18) ? 3 : 0, i + 1, 0, 1'b1);
    end
    step(1'b0, 1, 2);
    chk("draw19_done", 0, 0, 3, 19, 0, 1'b0);

    // Asynchronous reset in the middle of round 3.
    step(1'b1, 0, 0);
    step(1'b0, 2, 1);
    step(1'b0, 3, 2);
    chk("pre_rst", 1, 1, 0, 2, 2, 1'b1);
    @(negedge clk);
    bus.start = 1'b0; bus.p1 = 2'd1; bus.p2 = 2'd3;
    #2 rst = 1'b1;
    #1 chk("async_rst", 0, 0, 0, 0, 0, 1'b1);
    @(posedge clk);
    #1 chk("rst_held", 0, 0, 0, 0, 0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 2, 1);
    chk("post_rst_idle", 0, 0, 0, 0, 0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b1; bus.p1 = '0; bus.p2 = '0;
    @(posedge clk);
    #1 chk("start_on_release", 0, 0, 0, 0, 0, 1'b1);
    step(1'b0, 2, 1);
    chk("fresh_round", 1, 1, 0, 1, 1, 1'b1);

    // Five-move variant, repeats allowed.
    step5(1'b1, 0, 0);
    chk5("n5_start", 0, 0, 0, 0, 0);
    step5(1'b0, 1, 4);
    chk5("n5_1v4", 1, 1, 0, 1, 1);
    step5(1'b0, 1, 3);
    chk5("n5_1v3", 2, 1, 0, 2, 0);
    step5(1'b0, 6, 1);
    chk5("n5_6v1", 0, 1, 0, 2, 0);
    step5(1'b0, 5, 1);
    chk5("n5_5v1", 2, 1, 0, 3, -1);
    step5(1'b0, 4, 4);
    chk5("n5_end", 3, 1, 2, 4, -1);
    step5(1'b0, 1, 2);
    chk5("n5_done", 3, 0, 2, 4, -1);

    // Random play against the reference model.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_st = 0; m_round = 0; m_rv = 0; m_game = 0; m_played = 0; m_lead = 0;
    m_to_play = 0; m_prev_who = 0; m_prev_move = 0;
    for (int i = 0; i < 500; i++) begin
      bit s;
      int a, b;
      s = (i == 0) || ($urandom_range(0, 15) == 0);
      a = int'($urandom_range(0, 3));
      b = int'($urandom_range(0, 3));
      step(s, a, b);
      model_cycle(s, a, b);
      chk($sformatf("rnd%0d", i), m_round, m_rv, m_game, m_played, m_lead,
          (m_st != 2) || (m_rv == 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
